snn_spike_encoder: RTL and testbench

Rate-codes a small frame of 8-bit input intensities into a train of binary spike vectors, one vector per timestep, for the SNN multilayer core. It sits directly upstream of the multilayer inference stage. The host loads intensities through a byte-wide load port, then pulses `start`. The encoder emits `T_STEPS` spike vectors over a valid/ready handshake, using a reseeded 16-bit LFSR as its random source.

---
 rtl/snn_spike_encoder_if.sv | 24 ++
 rtl/snn_spike_encoder.sv | 73 +++++++
 tb/tb_snn_spike_encoder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_spike_encoder_if.sv
// snn_spike_encoder_if: pixel load port, frame start and spike-vector handshake for the spike encoder
interface snn_spike_encoder_if #(
  parameter int N_IN  = 4,
  parameter int PIX_W = 8
);
  logic             ld_valid;
  logic [3:0]       ld_idx;
  logic [PIX_W-1:0] ld_data;
  logic             start;
  logic             spk_valid;
  logic             spk_ready;
  logic [N_IN-1:0]  spk_vec;
  logic [7:0]       step_idx;
  logic             busy;
  logic             done;
  modport master (
    output ld_valid, ld_idx, ld_data, start, spk_ready,
    input  spk_valid, spk_vec, step_idx, busy, done
  );
  modport slave (
    input  ld_valid, ld_idx, ld_data, start, spk_ready,
    output spk_valid, spk_vec, step_idx, busy, done
  );
endinterface

// File: rtl/snn_spike_encoder.sv
// snn_spike_encoder: rate-codes N_IN pixel intensities into T_STEPS spike vectors using a reseeded Galois LFSR
module snn_spike_encoder #(
  parameter int          N_IN      = 4,
  parameter int          PIX_W     = 8,
  parameter int          T_STEPS   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                clk,
  input logic                rst_n,
  snn_spike_encoder_if.slave bus
);
  localparam int          NW   = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  typedef enum logic [1:0] {IDLE, GEN, PRESENT} state_t;
  state_t           r_state, w_state_nxt;
  logic [PIX_W-1:0] r_pix [N_IN];
  logic [15:0]      r_lfsr, w_lfsr_nxt;
  logic [NW-1:0]    r_n;
  logic [N_IN-1:0]  r_shadow, w_shadow_nxt, r_vec;
  logic [7:0]       r_step;
  logic             r_done, w_hs, w_last_n, w_last_step, w_ld_ok;
  always_comb begin
    w_hs        = (r_state == PRESENT) && bus.spk_ready;
    w_last_n    = r_n == NW'(N_IN - 1);
    w_last_step = r_step == 8'(T_STEPS - 1);
    w_ld_ok     = bus.ld_valid && ({1'b0, bus.ld_idx} < 5'(N_IN));
    w_lfsr_nxt  = r_lfsr[0] ? (r_lfsr >> 1) ^ 16'hB400 : r_lfsr >> 1;
    w_shadow_nxt = r_shadow;
    w_shadow_nxt[r_n] = r_pix[r_n] > r_lfsr[PIX_W-1:0];
    w_state_nxt = r_state;
    if (r_state == IDLE && bus.start) w_state_nxt = GEN;
    if (r_state == GEN && w_last_n) w_state_nxt = PRESENT;
    if (w_hs) w_state_nxt = w_last_step ? IDLE : GEN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  // the random sample is the pre-advance LFSR, so the LFSR only moves in GEN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pix    <= '{default: '0};
      r_lfsr   <= SEED;
      r_n      <= '0;
      r_shadow <= '0;
      r_vec    <= '0;
      r_step   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_hs && w_last_step;
      if (r_state == IDLE && w_ld_ok) r_pix[bus.ld_idx[NW-1:0]] <= bus.ld_data;
      if (r_state == IDLE && bus.start) begin
        r_lfsr   <= SEED;
        r_n      <= '0;
        r_step   <= '0;
        r_shadow <= '0;
      end
      if (r_state == GEN) begin
        r_shadow <= w_shadow_nxt;
        r_lfsr   <= w_lfsr_nxt;
        r_n      <= w_last_n ? '0 : r_n + 1'b1;
        if (w_last_n) r_vec <= w_shadow_nxt;
      end
      if (w_hs && !w_last_step) begin
        r_step <= r_step + 8'd1;
        r_n    <= '0;
      end
    end
  assign bus.spk_valid = r_state == PRESENT;
  assign bus.busy      = r_state != IDLE;
  assign bus.spk_vec   = r_vec;
  assign bus.step_idx  = r_step;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_snn_spike_encoder.sv
// tb_snn_spike_encoder: scoreboard bench; a reference LFSR model pushes the expected train at start, observed vectors are popped against it
module tb_snn_spike_encoder;
  typedef struct {logic [7:0] step; logic [3:0] vec;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  snn_spike_encoder_if #(.N_IN(4), .PIX_W(8)) bus();
  snn_spike_encoder #(.N_IN(4), .PIX_W(8), .T_STEPS(16), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  exp_t       q_exp[$];
  logic [7:0] m_pix [4];
  logic [3:0] obs_vec[$];
  logic [3:0] gold[$];
  logic [7:0] obs_step[$];
  int n_vec, n_err, done_cyc, ndone, stall_bad;
  bit busy_after, busy_at_done, tmo;

  task automatic load(input logic [3:0] idx, input logic [7:0] data);
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_idx = idx; bus.ld_data = data;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    if (idx < 4) m_pix[idx[1:0]] = data;
  endtask

  task automatic push_expected();
    logic [15:0] l = 16'hACE1;
    exp_t e;
    for (int t = 0; t < 16; t++) begin
      e.step = 8'(t);
      for (int n = 0; n < 4; n++) begin
        e.vec[n] = m_pix[n] > l[7:0];
        l = l[0] ? (l >> 1) ^ 16'hB400 : l >> 1;
      end
      q_exp.push_back(e);
    end
  endtask

  // drives one frame and records every accepted vector; cyc counts rising edges since the start edge
  task automatic run_frame(input int stall_at, input int stall_len, input bit ld_during, input bit start_mid);
    int cyc, stalled;
    logic [3:0] sv;
    logic [7:0] ss;
    bit fin;
    obs_vec.delete(); obs_step.delete();
    done_cyc = -1; ndone = 0; stall_bad = 0; stalled = 0; tmo = 0; fin = 0; busy_at_done = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.spk_ready = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!fin) begin
      bus.ld_valid = 1'b0; bus.start = 1'b0; bus.spk_ready = 1'b1;
      if (bus.done) begin
        ndone++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = bus.busy; end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) fin = 1;
      if (cyc >= 400) begin
        tmo = 1; fin = 1; n_err++;
        $display("FAIL frame_timeout: no done after %0d cycles, required done by 80", cyc);
      end
      if (ld_during && cyc == 10) begin bus.ld_valid = 1'b1; bus.ld_idx = 4'd0; bus.ld_data = 8'hFF; end
      if (stalled > 0 && stalled < stall_len && !bus.spk_valid) stall_bad++;
      if (bus.spk_valid) begin
        if (int'(bus.step_idx) == stall_at && stalled < stall_len) begin
          if (stalled == 0) begin sv = bus.spk_vec; ss = bus.step_idx; end
          else if (bus.spk_vec !== sv || bus.step_idx !== ss) stall_bad++;
          bus.spk_ready = 1'b0;
          stalled++;
        end else begin
          obs_vec.push_back(bus.spk_vec);
          obs_step.push_back(bus.step_idx);
        end
        if (start_mid && bus.step_idx == 8'd5) bus.start = 1'b1;
      end
      if (!fin) begin @(negedge clk); cyc++; end
    end
    busy_after = bus.busy;
  endtask

  task automatic test_reset();
    n_vec += 5;
    if (bus.spk_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.spk_valid); end
    if (bus.spk_vec !== 4'h0) begin n_err++; $display("FAIL reset_vec got %b want 0000", bus.spk_vec); end
    if (bus.step_idx !== 8'h0) begin n_err++; $display("FAIL reset_step got %0d want 0", bus.step_idx); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
  endtask

  task automatic test_all_zeros();
    for (int i = 0; i < 4; i++) load(4'(i), 8'h00);
    push_expected();
    run_frame(-1, 0, 0, 0);
    n_vec++;
    if (obs_vec.size() != 16) begin n_err++; $display("FAIL zeros_count got %0d want 16", obs_vec.size()); end
    for (int i = 0; i < obs_vec.size() && q_exp.size() > 0; i++) begin
      exp_t e = q_exp.pop_front();
      n_vec++;
      if (obs_vec[i] !== 4'b0000 || obs_vec[i] !== e.vec || obs_step[i] !== e.step)
        begin n_err++; $display("FAIL zeros_vec[%0d] got step %0d vec %b want step %0d vec %b", i, obs_step[i], obs_vec[i], e.step, e.vec); end
    end
    q_exp.delete();
    n_vec += 4;
    if (done_cyc != 80) begin n_err++; $display("FAIL zeros_done_time got %0d want 80", done_cyc); end
    if (ndone != 1) begin n_err++; $display("FAIL zeros_done_count got %0d want 1", ndone); end
    if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL zeros_busy_at_done got %b want 0", busy_at_done); end
    if (busy_after !== 1'b0) begin n_err++; $display("FAIL zeros_busy_after got %b want 0", busy_after); end
  endtask

  task automatic test_full_intensity();
    int ones = 0;
    for (int i = 0; i < 4; i++) load(4'(i), 8'hFF);
    push_expected();
    run_frame(-1, 0, 0, 0);
    n_vec++;
    if (obs_vec.size() != 16) begin n_err++; $display("FAIL full_count got %0d want 16", obs_vec.size()); end
    for (int i = 0; i < obs_vec.size() && q_exp.size() > 0; i++) begin
      exp_t e = q_exp.pop_front();
      n_vec++;
      if (obs_vec[i] !== e.vec || obs_step[i] !== e.step)
        begin n_err++; $display("FAIL full_vec[%0d] got step %0d vec %b want step %0d vec %b", i, obs_step[i], obs_vec[i], e.step, e.vec); end
      ones += $countones(obs_vec[i]);
    end
    q_exp.delete();
    n_vec++;
    if (ones < 60) begin n_err++; $display("FAIL full_density got %0d spikes want >= 60", ones); end
  endtask

  task automatic test_backpressure();
    load(4'd0, 8'd0); load(4'd1, 8'd64); load(4'd2, 8'd128); load(4'd3, 8'd255);
    push_expected();
    run_frame(-1, 0, 0, 0);
    gold = obs_vec;
    for (int i = 0; i < obs_vec.size() && q_exp.size() > 0; i++) begin
      exp_t e = q_exp.pop_front();
      n_vec++;
      if (obs_vec[i] !== e.vec || obs_step[i] !== e.step)
        begin n_err++; $display("FAIL bp_ref_vec[%0d] got step %0d vec %b want step %0d vec %b", i, obs_step[i], obs_vec[i], e.step, e.vec); end
    end
    q_exp.delete();
    push_expected();
    run_frame(3, 5, 0, 0);
    n_vec += 3;
    if (stall_bad != 0) begin n_err++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_bad); end
    if (obs_vec.size() != 16) begin n_err++; $display("FAIL bp_count got %0d want 16", obs_vec.size()); end
    if (done_cyc != 85) begin n_err++; $display("FAIL bp_done_time got %0d want 85", done_cyc); end
    for (int i = 0; i < obs_vec.size() && q_exp.size() > 0 && i < gold.size(); i++) begin
      exp_t e = q_exp.pop_front();
      n_vec++;
      if (obs_vec[i] !== e.vec || obs_step[i] !== e.step || obs_vec[i] !== gold[i])
        begin n_err++; $display("FAIL bp_vec[%0d] got step %0d vec %b want step %0d vec %b", i, obs_step[i], obs_vec[i], e.step, e.vec); end
    end
    q_exp.delete();
  endtask

  task automatic test_repro_lockout();
    load(4'd0, 8'd10); load(4'd1, 8'd200); load(4'd2, 8'd90); load(4'd3, 8'd30);
    load(4'd7, 8'hFF);
    push_expected();
    run_frame(-1, 0, 1, 0);
    gold = obs_vec;
    for (int i = 0; i < obs_vec.size() && q_exp.size() > 0; i++) begin
      exp_t e = q_exp.pop_front();
      n_vec++;
      if (obs_vec[i] !== e.vec || obs_step[i] !== e.step)
        begin n_err++; $display("FAIL lock_vec[%0d] got step %0d vec %b want step %0d vec %b", i, obs_step[i], obs_vec[i], e.step, e.vec); end
    end
    q_exp.delete();
    push_expected();
    run_frame(-1, 0, 0, 0);
    n_vec++;
    if (obs_vec.size() != 16) begin n_err++; $display("FAIL repro_count got %0d want 16", obs_vec.size()); end
    for (int i = 0; i < obs_vec.size() && q_exp.size() > 0 && i < gold.size(); i++) begin
      exp_t e = q_exp.pop_front();
      n_vec++;
      if (obs_vec[i] !== e.vec || obs_vec[i] !== gold[i])
        begin n_err++; $display("FAIL repro_vec[%0d] got %b want %b (first run %b)", i, obs_vec[i], e.vec, gold[i]); end
    end
    q_exp.delete();
  endtask

  task automatic test_start_busy();
    push_expected();
    run_frame(-1, 0, 0, 1);
    n_vec += 3;
    if (obs_vec.size() != 16) begin n_err++; $display("FAIL sb_count got %0d want 16", obs_vec.size()); end
    if (ndone != 1) begin n_err++; $display("FAIL sb_done_count got %0d want 1", ndone); end
    if (done_cyc != 80) begin n_err++; $display("FAIL sb_done_time got %0d want 80", done_cyc); end
    for (int i = 0; i < obs_vec.size() && q_exp.size() > 0; i++) begin
      exp_t e = q_exp.pop_front();
      n_vec++;
      if (obs_vec[i] !== e.vec || obs_step[i] !== e.step)
        begin n_err++; $display("FAIL sb_vec[%0d] got step %0d vec %b want step %0d vec %b", i, obs_step[i], obs_vec[i], e.step, e.vec); end
    end
    q_exp.delete();
  endtask

  task automatic test_reset_midframe();
    bit found = 0;
    load(4'd0, 8'd50); load(4'd1, 8'd100); load(4'd2, 8'd150); load(4'd3, 8'd200);
    @(negedge clk);
    bus.start = 1'b1; bus.spk_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (bus.spk_valid && bus.step_idx == 8'd7) found = 1;
      @(negedge clk);
    end
    n_vec += 2;
    if (!found) begin n_err++; $display("FAIL rst_reach_step7 timeout, step %0d", bus.step_idx); end
    if (bus.busy !== 1'b1 || bus.spk_valid !== 1'b0 || bus.step_idx !== 8'd8)
      begin n_err++; $display("FAIL rst_in_gen got busy %b valid %b step %0d want 1 0 8", bus.busy, bus.spk_valid, bus.step_idx); end
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_pix[i] = 8'd0;
    push_expected();
    run_frame(-1, 0, 0, 0);
    n_vec++;
    if (obs_vec.size() != 16) begin n_err++; $display("FAIL rst_count got %0d want 16", obs_vec.size()); end
    for (int i = 0; i < obs_vec.size() && q_exp.size() > 0; i++) begin
      exp_t e = q_exp.pop_front();
      n_vec++;
      if (obs_vec[i] !== e.vec || obs_step[i] !== e.step)
        begin n_err++; $display("FAIL rst_vec[%0d] got step %0d vec %b want step %0d vec %b", i, obs_step[i], obs_vec[i], e.step, e.vec); end
    end
    q_exp.delete();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    bus.ld_valid = 1'b0; bus.ld_idx = 4'd0; bus.ld_data = 8'd0;
    bus.start = 1'b0; bus.spk_ready = 1'b1;
    for (int i = 0; i < 4; i++) m_pix[i] = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_all_zeros();
    test_full_intensity();
    test_backpressure();
    test_repro_lockout();
    test_start_busy();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
